spi_master_multi: RTL and testbench

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_clk_gen.sv | 37 +++
 rtl/spi_master_multi.sv | 140 ++++++++++++++
 tb/tb_spi_master_multi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and SPI mode-field bit positions for spi_master_multi
package spi_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_TRAIL, S_GAP} state_t;
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: CLK_DIV half-period counter (clk, rst, en/tog/set/set_val/cpol in; tick, lead, trail, sclk out)
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tog,
  input  logic set,
  input  logic set_val,
  input  logic cpol,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic sclk
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic sclk_q, sclk_d;
  assign tick = cnt_q == CW'(CLK_DIV - 1);
  assign lead = tick && tog && (sclk_q == cpol);
  assign trail = tick && tog && (sclk_q != cpol);
  assign sclk = sclk_q;
  always_comb begin
    cnt_d = (en && !tick) ? cnt_q + 1'b1 : '0;
    sclk_d = set ? set_val : (tick && tog) ? ~sclk_q : sclk_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi: multi-slave SPI master (i_* clock/reset/data/control in; o_MOSI/o_SCLK/o_SS pins and o_* status out; define SPI_BURST_EN for back-to-back words)
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int CLK_DIV = 4,
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_MISO,
  input  logic [DATA_W-1:0] i_DIN,
  input  logic              i_LD_DIN,
  input  logic [SS_W-1:0]   i_SS_SEL,
  input  logic [1:0]        i_MODE,
  input  logic              i_DATA_READ,
  output logic              o_MOSI,
  output logic              o_SCLK,
  output logic [NUM_SS-1:0] o_SS,
  output logic [DATA_W-1:0] o_MISO_DATA,
  output logic              o_DIN_EMPTY,
  output logic              o_DATA_READY,
  output logic              o_OVERRUN,
  output logic              o_BUSY
);
  localparam int EW = $clog2(2 * DATA_W + 1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, tx_q, tx_d, rx_q, rx_d, data_q, data_d;
  logic full_q, full_d, mosi_q, mosi_d, ready_q, ready_d, ovr_q, ovr_d;
  logic [1:0] mode_q, mode_d;
  logic [SS_W-1:0] sel_q, sel_d;
  logic [NUM_SS-1:0] ss_q, ss_d;
  logic [EW-1:0] edge_q, edge_d;
  logic start, burst, tick, lead, trail, take;
  assign start = state_q == S_IDLE && full_q;
`ifdef SPI_BURST_EN
  assign burst = state_q == S_TRAIL && full_q;
`else
  assign burst = 1'b0;
`endif
  // a burst word reuses the trail half-period as its lead-in, so its first edge fires on the TRAIL tick
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk(i_clk), .rst(i_rst), .en(state_q != S_IDLE), .tog(state_q == S_XFER || burst),
    .set(start), .set_val(i_MODE[CPOL_BIT]), .cpol(mode_q[CPOL_BIT]),
    .tick(tick), .lead(lead), .trail(trail), .sclk(o_SCLK)
  );
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    full_d = full_q;
    tx_d = tx_q;
    rx_d = rx_q;
    mosi_d = mosi_q;
    mode_d = mode_q;
    sel_d = sel_q;
    edge_d = edge_q;
    data_d = data_q;
    ovr_d = ovr_q;
    ready_d = ready_q && !i_DATA_READ;
    take = 1'b0;
    if (i_LD_DIN && !full_q) begin
      hold_d = i_DIN;
      full_d = 1'b1;
    end
    if (mode_q[CPHA_BIT] ? trail : lead) rx_d = {rx_q[DATA_W-2:0], i_MISO};
    // tx_q holds the bits not yet placed on MOSI
    if (mode_q[CPHA_BIT] ? lead : trail) begin
      mosi_d = tx_q[DATA_W-1];
      tx_d = tx_q << 1;
    end
    case (state_q)
      S_IDLE: if (full_q) begin
        state_d = S_SETUP;
        take = 1'b1;
        mode_d = i_MODE;
        sel_d = i_SS_SEL;
      end
      S_SETUP: if (tick) state_d = S_XFER;
      S_XFER: if (tick) begin
        edge_d = edge_q + 1'b1;
        if (edge_q == EW'(2 * DATA_W - 1)) state_d = S_TRAIL;
      end
      S_TRAIL: if (tick) begin
        data_d = rx_q;
        ready_d = 1'b1;
        ovr_d = ovr_q || ready_q;
        state_d = burst ? S_XFER : S_GAP;
        take = burst;
        edge_d = burst ? EW'(1) : '0;
      end
      S_GAP: if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // CPHA=0 needs the MSB on the wire before the first edge; a burst load coincides with a launch edge
    if (take) begin
      full_d = 1'b0;
      {mosi_d, tx_d} = (burst || !mode_d[CPHA_BIT]) ? {hold_q[DATA_W-1], hold_q << 1} : {mosi_q, hold_q};
    end
    ss_d = (state_d == S_IDLE || state_d == S_GAP) ? '1 : ~(NUM_SS'(1) << sel_d);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      hold_q <= '0;
      full_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      mosi_q <= 1'b0;
      mode_q <= '0;
      sel_q <= '0;
      ss_q <= '1;
      edge_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      full_q <= full_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      mosi_q <= mosi_d;
      mode_q <= mode_d;
      sel_q <= sel_d;
      ss_q <= ss_d;
      edge_q <= edge_d;
      data_q <= data_d;
      ready_q <= ready_d;
      ovr_q <= ovr_d;
    end
  end
  assign o_MOSI = mosi_q;
  assign o_SS = ss_q;
  assign o_MISO_DATA = data_q;
  assign o_DIN_EMPTY = !full_q;
  assign o_DATA_READY = ready_q;
  assign o_OVERRUN = ovr_q;
  assign o_BUSY = state_q != S_IDLE;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed and randomized checks of spi_master_multi against a behavioural SPI slave monitor
module tb_spi_master_multi;
  localparam int W = 8, N = 4, D = 4, LIM = 2000;
  logic clk = 1'b0, rst = 1'b1, ld = 1'b0, rd = 1'b0, loop = 1'b0, miso_c = 1'b0;
  logic [W-1:0] din = '0;
  logic [1:0] sel = '0, mode = '0;
  logic miso, mosi, sclk, empty, ready, ovr, busy;
  logic [N-1:0] ss;
  logic [W-1:0] mdata;
  int checks = 0, failures = 0;
  logic cpol = 1'b0, cpha = 1'b0;
  int runs[$], gaps[$];
  bit mbits[$];
  int low_run = 0, high_run = 0, mosi_bad = 0;
  logic [N-1:0] ss_seen = '1;
  logic sclk_p = 1'b0, mosi_p = 1'b0, ss_low_p = 1'b0;
  logic [W-1:0] w, wa, wb, wc;
  logic [1:0] m, s;
  logic [N-1:0] e;

  always #5 clk = ~clk;
  assign miso = loop ? mosi : miso_c;

  spi_master_multi #(.DATA_W(W), .NUM_SS(N), .CLK_DIV(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_MISO(miso), .i_DIN(din), .i_LD_DIN(ld),
    .i_SS_SEL(sel), .i_MODE(mode), .i_DATA_READ(rd), .o_MOSI(mosi), .o_SCLK(sclk),
    .o_SS(ss), .o_MISO_DATA(mdata), .o_DIN_EMPTY(empty), .o_DATA_READY(ready),
    .o_OVERRUN(ovr), .o_BUSY(busy)
  );

  // slave-side view: select windows, gaps, and MOSI bits taken on the sampling edge of the configured mode
  always @(negedge clk) begin
    if (ss != '1) begin
      if (high_run > 0) gaps.push_back(high_run);
      high_run = 0;
      low_run++;
      ss_seen = ss;
    end else begin
      if (low_run > 0) runs.push_back(low_run);
      low_run = 0;
      high_run++;
    end
    if (ss_low_p && ss != '1 && sclk !== sclk_p && ((sclk_p == cpol) != cpha)) mosi_bits_push();
    if (busy && mosi !== mosi_p && !(sclk_p && !sclk)) mosi_bad++;
    sclk_p = sclk;
    mosi_p = mosi;
    ss_low_p = (ss != '1);
  end

  function automatic void mosi_bits_push();
    mbits.push_back(mosi);
  endfunction

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    runs.delete();
    gaps.delete();
    mbits.delete();
    low_run = 0;
    high_run = 0;
    mosi_bad = 0;
  endtask

  task automatic load(logic [W-1:0] v);
    din = v;
    ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  task automatic ack();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic set_mode(logic [1:0] mm, logic [1:0] ssel);
    mode = mm;
    sel = ssel;
    cpol = mm[1];
    cpha = mm[0];
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    while ((busy || !empty) && n < LIM) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < LIM), 1);
  endtask

  function automatic logic [31:0] bits();
    logic [31:0] v = '0;
    foreach (mbits[i]) v = {v[30:0], mbits[i]};
    return v;
  endfunction

  function automatic int run_at(int i);
    return (runs.size() > i) ? runs[i] : -1;
  endfunction

  initial begin
    step(3);
    chk("rst_ss", 32'(ss), 32'hF);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_data", 32'(mdata), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step(2);
    chk("idle_sclk", 32'(sclk), 0);

    set_mode(2'b00, 2'd2);
    miso_c = 1'b1;
    clear();
    load(8'hAA);
    wait_done("m0");
    chk("m0_runs", 32'(runs.size()), 1);
    chk("m0_len", 32'(run_at(0)), 72);
    chk("m0_ss", 32'(ss_seen), 32'b1011);
    chk("m0_nbits", 32'(mbits.size()), 8);
    chk("m0_mosi", bits(), 32'hAA);
    chk("m0_rx", 32'(mdata), 32'hFF);
    chk("m0_ready", 32'(ready), 1);
    ack();
    chk("m0_ack", 32'(ready), 0);

    set_mode(2'b11, 2'd1);
    loop = 1'b1;
    clear();
    load(8'h5A);
    wait_done("m3");
    chk("m3_sclk_idle", 32'(sclk), 1);
    chk("m3_mosi_fall", 32'(mosi_bad), 0);
    chk("m3_mosi", bits(), 32'h5A);
    chk("m3_rx", 32'(mdata), 32'h5A);
    ack();

    for (int k = 0; k < 6; k++) begin
      w = W'($urandom);
      m = 2'($urandom);
      s = 2'($urandom);
      e = '1;
      e[s] = 1'b0;
      set_mode(m, s);
      clear();
      load(w);
      wait_done("rnd");
      chk("rnd_len", 32'(run_at(0)), 72);
      chk("rnd_ss", 32'(ss_seen), 32'(e));
      chk("rnd_mosi", bits(), 32'(w));
      chk("rnd_rx", 32'(mdata), 32'(w));
      chk("rnd_ready", 32'(ready), 1);
      ack();
    end

    chk("ovr_clear", 32'(ovr), 0);
    wa = W'($urandom);
    wb = ~wa;
    set_mode(2'($urandom), 2'd0);
    load(wa);
    wait_done("ovr1");
    load(wb);
    wait_done("ovr2");
    chk("ovr_set", 32'(ovr), 1);
    chk("ovr_data", 32'(mdata), 32'(wb));
    chk("ovr_ready", 32'(ready), 1);
    ack();
    chk("ovr_ack_ready", 32'(ready), 0);
    chk("ovr_sticky", 32'(ovr), 1);

    wa = W'($urandom);
    wb = wa ^ 8'h3C;
    wc = ~wb;
    set_mode(2'b01, 2'd3);
    clear();
    load(wa);
    step(10);
    load(wb);
    chk("drop_full", 32'(empty), 0);
    load(wc);
    wait_done("drop");
    chk("drop_nbits", 32'(mbits.size()), 16);
    chk("drop_mosi", bits(), {16'h0, wa, wb});
    chk("drop_rx", 32'(mdata), 32'(wb));
    step(20);
    chk("drop_no_third", 32'(busy), 0);
    ack();

    set_mode(2'b01, 2'd0);
    clear();
    load(8'hAA);
    step(18);
    load(8'hA5);
    wait_done("burst");
`ifdef SPI_BURST_EN
    chk("burst_runs", 32'(runs.size()), 1);
    chk("burst_len", 32'(run_at(0)), 136);
`else
    chk("gap_runs", 32'(runs.size()), 2);
    chk("gap_len0", 32'(run_at(0)), 72);
    chk("gap_len1", 32'(run_at(1)), 72);
    chk("gap_high", 32'(gaps.size() > 0 && gaps[gaps.size()-1] >= 4), 1);
`endif
    chk("burst_mosi", bits(), 32'hAAA5);
    chk("burst_rx", 32'(mdata), 32'hA5);
    ack();

    set_mode(2'b00, 2'd1);
    clear();
    load(8'h3C);
    step(29);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ss", 32'(ss), 32'hF);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_ovr", 32'(ovr), 0);
    chk("mid_rst_sclk", 32'(sclk), 0);
    step(100);
    chk("mid_rst_no_ready", 32'(ready), 0);
    chk("mid_rst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
